// File: rtl/v_cu_pkg.sv
// Shared vector-CU definitions used by the write-port occupancy tracker.
//   port_state_t    : per-group tracker state (IDLE, ISSUE, DRAIN)
//   VLANE_NUM_LOG2  : log2 of the lanes served by one batch
//   WDOG_MAX        : drain watchdog terminal count (PORT_TRACK_TIMEOUT_EN builds)
//   *_DFLT          : default sizing for the tracker, its groups and its interface
package v_cu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } port_state_t;

  localparam int VLANE_NUM_LOG2   = 3;
  localparam int VLANE_NUM_DFLT   = 1 << VLANE_NUM_LOG2;
  localparam int W_PORTS_NUM_DFLT = 4;
  localparam int VL_W_DFLT        = 13;

  localparam int                WDOG_W   = 10;
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

endpackage

// File: rtl/port_busy_tracker_if.sv
// Handshake bundle between the port allocator / lane writeback side and the
// write-port busy tracker.
//   start_i, vl_i   : one-hot group start and the vector length it carries
//   stall_i         : per-group lane backpressure on batch issue
//   wr_ack_i        : per-group batch writeback completion
//   issue_vld_o, issue_idx_o, last_o : per-group batch issue (idx packed g*BATCH_W)
//   port_rdy_o      : per-group idle / allocatable
//   err_o           : per-group drain watchdog error, only with PORT_TRACK_TIMEOUT_EN
// Modports: master = allocator/lane side, slave = tracker.
interface port_busy_tracker_if #(
  parameter int W_PORTS_NUM = v_cu_pkg::W_PORTS_NUM_DFLT,
  parameter int VLANE_NUM   = v_cu_pkg::VLANE_NUM_DFLT,
  parameter int VL_W        = v_cu_pkg::VL_W_DFLT,
  parameter int BATCH_W     = VL_W - $clog2(VLANE_NUM) + 1
);

  logic [W_PORTS_NUM-1:0]         start_i;
  logic [VL_W-1:0]                vl_i;
  logic [W_PORTS_NUM-1:0]         stall_i;
  logic [W_PORTS_NUM-1:0]         wr_ack_i;
  logic [W_PORTS_NUM-1:0]         issue_vld_o;
  logic [W_PORTS_NUM*BATCH_W-1:0] issue_idx_o;
  logic [W_PORTS_NUM-1:0]         last_o;
  logic [W_PORTS_NUM-1:0]         port_rdy_o;
`ifdef PORT_TRACK_TIMEOUT_EN
  logic [W_PORTS_NUM-1:0]         err_o;
`endif

  modport master (
    output start_i, vl_i, stall_i, wr_ack_i,
`ifdef PORT_TRACK_TIMEOUT_EN
    input  err_o,
`endif
    input  issue_vld_o, issue_idx_o, last_o, port_rdy_o
  );

  modport slave (
    input  start_i, vl_i, stall_i, wr_ack_i,
`ifdef PORT_TRACK_TIMEOUT_EN
    output err_o,
`endif
    output issue_vld_o, issue_idx_o, last_o, port_rdy_o
  );

endinterface

// File: rtl/port_group_fsm.sv
// One write-port group of the busy tracker. A start with a non-zero vector
// length latches the batch count ceil(vl/VLANE_NUM), issues that many batches
// (honouring stall), then waits until every batch has been acknowledged before
// reporting ready again.
// Optional macro PORT_TRACK_TIMEOUT_EN adds a drain watchdog and sticky err.
// Ports:
//   clk, rstn         : clock, synchronous active-low reset
//   start, vl         : start pulse and vector length (sampled only with start)
//   stall             : suppresses issue this cycle
//   wr_ack            : one batch writeback completed
//   issue_vld, issue_idx, last : batch issue strobe, batch index, final batch
//   port_rdy          : group idle
//   err               : watchdog expired (PORT_TRACK_TIMEOUT_EN only)
module port_group_fsm
  import v_cu_pkg::*;
#(
  parameter int VLANE_NUM = VLANE_NUM_DFLT,
  parameter int VL_W      = VL_W_DFLT,
  parameter int BATCH_W   = VL_W - $clog2(VLANE_NUM) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [VL_W-1:0]    vl,
  input  logic               stall,
  input  logic               wr_ack,
  output logic               issue_vld,
  output logic [BATCH_W-1:0] issue_idx,
  output logic               last,
  output logic               port_rdy
`ifdef PORT_TRACK_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  localparam int                 SHIFT = $clog2(VLANE_NUM);
  localparam int                 SUM_W = VL_W + 1;
  localparam logic [BATCH_W-1:0] ONE   = BATCH_W'(1);

  port_state_t        state;
  logic [BATCH_W-1:0] nb;
  logic [BATCH_W-1:0] issued;
  logic [BATCH_W-1:0] acked;
  logic [SUM_W-1:0]   vl_sum;
  logic [BATCH_W-1:0] nb_next;
  logic               ack_ok;
  logic               last_batch;

`ifdef PORT_TRACK_TIMEOUT_EN
  logic [WDOG_W-1:0]  wdog;
`endif

  // One extra bit keeps the rounding add from wrapping at the maximum vl.
  assign vl_sum  = {1'b0, vl} + SUM_W'(VLANE_NUM - 1);
  assign nb_next = BATCH_W'(vl_sum >> SHIFT);

  // An ack is only legal while some issued batch is still outstanding;
  // otherwise it is dropped so the count saturates at the issued count.
  assign ack_ok     = wr_ack && (acked != issued);
  assign last_batch = (issued == nb - ONE);

  // Outputs decode directly from state so ready/issue react with no extra latency.
  assign port_rdy  = (state == IDLE);
  assign issue_vld = (state == ISSUE) && !stall;
  assign issue_idx = (state == ISSUE) ? issued : '0;
  assign last      = issue_vld && last_batch;

  // NOTE: state uses non-blocking assignments so every branch below reads the
  // pre-edge values of the counters, exactly as the output decode above does.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      nb     <= '0;
      issued <= '0;
      acked  <= '0;
`ifdef PORT_TRACK_TIMEOUT_EN
      wdog   <= '0;
      err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // A zero-length start carries no batches and leaves the group ready.
          if (start && (vl != '0)) begin
            nb     <= nb_next;
            issued <= '0;
            acked  <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            issued <= issued + ONE;
            if (last_batch) state <= DRAIN;
          end
          if (ack_ok) acked <= acked + ONE;
`ifdef PORT_TRACK_TIMEOUT_EN
          wdog <= '0;
`endif
        end
        DRAIN: begin
          if (acked == nb) begin
            state <= IDLE;
`ifdef PORT_TRACK_TIMEOUT_EN
          end else if (wdog == WDOG_MAX) begin
            // Writebacks stopped arriving: flag it and free the port anyway.
            err   <= 1'b1;
            state <= IDLE;
`endif
          end else if (ack_ok) begin
            acked <= acked + ONE;
          end
`ifdef PORT_TRACK_TIMEOUT_EN
          wdog <= wr_ack ? '0 : wdog + WDOG_W'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/port_busy_tracker.sv
// Per-write-port-group occupancy tracker of the vector CU. Consumes the
// allocator's one-hot start pulses and returns the per-group ready vector the
// allocator arbitrates on. Each group is an independent port_group_fsm; this
// level only packs the per-group signals onto the interface.
// Optional macro PORT_TRACK_TIMEOUT_EN enables the per-group drain watchdog
// and the err_o vector.
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : port_busy_tracker_if.slave (start/vl/stall/ack in, issue/ready out)
module port_busy_tracker
  import v_cu_pkg::*;
#(
  parameter int W_PORTS_NUM = W_PORTS_NUM_DFLT,
  parameter int VLANE_NUM   = VLANE_NUM_DFLT,
  parameter int VL_W        = VL_W_DFLT,
  parameter int BATCH_W     = VL_W - $clog2(VLANE_NUM) + 1
) (
  input logic                clk,
  input logic                rstn,
  port_busy_tracker_if.slave bus
);

  for (genvar g = 0; g < W_PORTS_NUM; g++) begin : g_grp
    port_group_fsm #(
      .VLANE_NUM (VLANE_NUM),
      .VL_W      (VL_W),
      .BATCH_W   (BATCH_W)
    ) u_fsm (
      .clk       (clk),
      .rstn      (rstn),
      .start     (bus.start_i[g]),
      .vl        (bus.vl_i),
      .stall     (bus.stall_i[g]),
      .wr_ack    (bus.wr_ack_i[g]),
      .issue_vld (bus.issue_vld_o[g]),
      .issue_idx (bus.issue_idx_o[g*BATCH_W +: BATCH_W]),
      .last      (bus.last_o[g]),
      .port_rdy  (bus.port_rdy_o[g])
`ifdef PORT_TRACK_TIMEOUT_EN
      ,
      .err       (bus.err_o[g])
`endif
    );
  end

endmodule

// File: tb/tb_port_busy_tracker.sv
// Self-checking bench for port_busy_tracker. A count-based model (batches
// owed, issued, acknowledged per group) predicts the outputs every cycle;
// directed sequences add hand-computed spot checks.
// Build with PORT_TRACK_TIMEOUT_EN to also exercise the drain watchdog.
module tb_port_busy_tracker;

  localparam int W_PORTS_NUM = 4;
  localparam int VLANE_NUM   = 8;
  localparam int VL_W        = 13;
  localparam int BATCH_W     = VL_W - $clog2(VLANE_NUM) + 1;
  localparam int WDOG_LIMIT  = 1023;
`ifdef PORT_TRACK_TIMEOUT_EN
  localparam bit TIMEOUT_EN  = 1'b1;
`else
  localparam bit TIMEOUT_EN  = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  port_busy_tracker_if #(
    .W_PORTS_NUM (W_PORTS_NUM),
    .VLANE_NUM   (VLANE_NUM),
    .VL_W        (VL_W),
    .BATCH_W     (BATCH_W)
  ) bus ();

  port_busy_tracker #(
    .W_PORTS_NUM (W_PORTS_NUM),
    .VLANE_NUM   (VLANE_NUM),
    .VL_W        (VL_W),
    .BATCH_W     (BATCH_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit m_on = 1'b0;
  bit m_busy [W_PORTS_NUM];
  int m_nb   [W_PORTS_NUM];
  int m_iss  [W_PORTS_NUM];
  int m_ack  [W_PORTS_NUM];
  int m_run  [W_PORTS_NUM];
  bit m_err  [W_PORTS_NUM];
  int m_viol    = 0;
  int m_ack_err = 0;

  task automatic model_ack(input int g);
    if (m_ack[g] < m_iss[g]) m_ack[g]++;
    else begin
      m_ack_err++;
      $display("[TB] protocol: ack with nothing outstanding on group %0d dropped", g);
    end
  endtask

  task automatic model_step();
    if (!rstn) begin
      m_on = 1'b1;
      for (int g = 0; g < W_PORTS_NUM; g++) begin
        m_busy[g] = 1'b0; m_nb[g] = 0; m_iss[g] = 0; m_ack[g] = 0;
        m_run[g] = 0;     m_err[g] = 1'b0;
      end
    end else begin
      for (int g = 0; g < W_PORTS_NUM; g++) begin
        if (!m_busy[g]) begin
          if (bus.start_i[g] && bus.vl_i != 0) begin
            m_busy[g] = 1'b1;
            m_nb[g]   = (int'(bus.vl_i) + VLANE_NUM - 1) / VLANE_NUM;
            m_iss[g]  = 0; m_ack[g] = 0; m_run[g] = 0;
          end
        end else begin
          if (bus.start_i[g]) begin
            m_viol++;
            $display("[TB] protocol: start on busy group %0d ignored", g);
          end
          if (m_iss[g] < m_nb[g]) begin
            if (bus.wr_ack_i[g]) model_ack(g);
            if (!bus.stall_i[g]) m_iss[g]++;
          end else begin
            if (m_ack[g] == m_nb[g]) begin
              if (bus.wr_ack_i[g]) model_ack(g);
              m_busy[g] = 1'b0;
            end else if (TIMEOUT_EN && m_run[g] == WDOG_LIMIT) begin
              m_err[g]  = 1'b1;
              m_busy[g] = 1'b0;
            end else if (bus.wr_ack_i[g]) begin
              model_ack(g);
            end
            m_run[g] = bus.wr_ack_i[g] ? 0 : m_run[g] + 1;
          end
        end
      end
    end
  endtask

  task automatic compare_cycle();
    logic [W_PORTS_NUM-1:0] e_rdy, e_vld, e_last, e_err;
    e_rdy = '0; e_vld = '0; e_last = '0; e_err = '0;
    for (int g = 0; g < W_PORTS_NUM; g++) begin
      e_rdy[g]  = !m_busy[g];
      e_vld[g]  = m_busy[g] && (m_iss[g] < m_nb[g]) && !bus.stall_i[g];
      e_last[g] = e_vld[g] && (m_iss[g] == m_nb[g] - 1);
      e_err[g]  = m_err[g];
    end
    check("cyc port_rdy", bus.port_rdy_o, e_rdy);
    check("cyc issue_vld", bus.issue_vld_o, e_vld);
    check("cyc last", bus.last_o, e_last);
    for (int g = 0; g < W_PORTS_NUM; g++)
      if (e_vld[g])
        check($sformatf("cyc issue_idx[%0d]", g), bus.issue_idx_o[g*BATCH_W +: BATCH_W], m_iss[g]);
`ifdef PORT_TRACK_TIMEOUT_EN
    check("cyc err", bus.err_o, e_err);
`else
    if (e_err != '0) check("cyc err model", e_err, '0);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_on) compare_cycle();
    end
  end

  initial begin
    #2000000;
    $display("FAIL time_limit: got still running, expected finished");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input int vl, input logic [3:0] st, input logic [3:0] ak);
    bus.start_i  = s;
    bus.vl_i     = VL_W'(vl);
    bus.stall_i  = st;
    bus.wr_ack_i = ak;
  endtask

  initial begin
    int k, n_iss, n_ack, last_idx;
    rstn = 1'b0;
    drive(4'h0, 0, 4'h0, 4'h0);
    tick(); tick();

    // 1: reset state, then idle
    check("rst port_rdy", bus.port_rdy_o, 4'hf);
    check("rst issue_vld", bus.issue_vld_o, 4'h0);
    check("rst last", bus.last_o, 4'h0);
    check("rst issue_idx", bus.issue_idx_o, 0);
`ifdef PORT_TRACK_TIMEOUT_EN
    check("rst err", bus.err_o, 4'h0);
`endif
    rstn = 1'b1;
    repeat (5) tick();
    check("idle port_rdy", bus.port_rdy_o, 4'hf);
    check("idle issue_vld", bus.issue_vld_o, 4'h0);

    // 2: group 0, vl=20 -> 3 batches, ack one cycle after each issue
    drive(4'b0001, 20, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t2 rdy drop", bus.port_rdy_o, 4'b1110);
    check("t2 vld idx0", bus.issue_vld_o, 4'b0001);
    check("t2 idx0", bus.issue_idx_o[BATCH_W-1:0], 0);
    tick();
    drive(4'h0, 0, 4'h0, 4'b0001); #1;
    check("t2 idx1", bus.issue_idx_o[BATCH_W-1:0], 1);
    tick();
    drive(4'h0, 0, 4'h0, 4'b0001); #1;
    check("t2 idx2", bus.issue_idx_o[BATCH_W-1:0], 2);
    check("t2 last", bus.last_o, 4'b0001);
    tick();
    drive(4'h0, 0, 4'h0, 4'b0001); #1;
    check("t2 drain no issue", bus.issue_vld_o, 4'h0);
    tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t2 rdy 1 after ack", bus.port_rdy_o, 4'b1110);
    tick();
    check("t2 rdy 2 after ack", bus.port_rdy_o, 4'hf);

    // 3: group 1, vl=16 -> 2 batches, start during stall, 3-cycle stall mid-issue
    drive(4'b0010, 16, 4'b0010, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t3 vld idx0", bus.issue_vld_o, 4'b0010);
    check("t3 idx0", bus.issue_idx_o[BATCH_W +: BATCH_W], 0);
    tick();
    drive(4'h0, 0, 4'b0010, 4'b0010); #1;
    check("t3 stalled", bus.issue_vld_o, 4'h0);
    tick();
    drive(4'h0, 0, 4'b0010, 4'h0); tick();
    drive(4'h0, 0, 4'b0010, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t3 vld idx1", bus.issue_vld_o, 4'b0010);
    check("t3 idx1", bus.issue_idx_o[BATCH_W +: BATCH_W], 1);
    check("t3 last", bus.last_o, 4'b0010);
    tick();
    drive(4'h0, 0, 4'h0, 4'b0010); tick();
    drive(4'h0, 0, 4'h0, 4'h0); tick();
    check("t3 rdy back", bus.port_rdy_o, 4'hf);

    // 4: simultaneous start on groups 0 and 2, vl=8 -> single batch each
    drive(4'b0101, 8, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t4 vld", bus.issue_vld_o, 4'b0101);
    check("t4 last", bus.last_o, 4'b0101);
    check("t4 rdy", bus.port_rdy_o, 4'b1010);
    tick();
    drive(4'h0, 0, 4'h0, 4'b0101); tick();
    drive(4'h0, 0, 4'h0, 4'h0); tick();
    check("t4 rdy back", bus.port_rdy_o, 4'hf);

    // 5: zero-length start, start while draining, acks with nothing outstanding
    drive(4'b1000, 0, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t5 vl0 rdy", bus.port_rdy_o, 4'hf);
    check("t5 vl0 vld", bus.issue_vld_o, 4'h0);
    tick();
    drive(4'b0001, 8, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); tick();
    drive(4'b0001, 40, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t5 busy start ignored vld", bus.issue_vld_o, 4'h0);
    check("t5 busy start ignored rdy", bus.port_rdy_o, 4'b1110);
    tick();
    drive(4'h0, 0, 4'h0, 4'b0001); tick();
    drive(4'h0, 0, 4'h0, 4'h0); tick();
    check("t5 g0 rdy back", bus.port_rdy_o, 4'hf);
    drive(4'h0, 0, 4'h0, 4'hf); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t5 idle ack ignored", bus.port_rdy_o, 4'hf);
    drive(4'b0100, 16, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'b0100); tick();
    drive(4'h0, 0, 4'h0, 4'b0100); tick();
    drive(4'h0, 0, 4'h0, 4'b0100); tick();
    drive(4'h0, 0, 4'h0, 4'b0100); #1;
    check("t5 spurious acks dropped", bus.port_rdy_o, 4'b1011);
    tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("t5 g2 rdy back", bus.port_rdy_o, 4'hf);
    check("t5 busy-start flags", m_viol, 1);
    check("t5 dropped-ack flags", m_ack_err, 2);

    // reset in the middle of issue aborts everything
    drive(4'b0100, 64, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0); tick();
    rstn = 1'b0; tick();
    check("mid rst rdy", bus.port_rdy_o, 4'hf);
    check("mid rst vld", bus.issue_vld_o, 4'h0);
    rstn = 1'b1;
    drive(4'h0, 0, 4'h0, 4'b0100); tick();
    drive(4'h0, 0, 4'h0, 4'h0); #1;
    check("post rst ack ignored", bus.port_rdy_o, 4'hf);

    // largest vector length: 8191 -> 1024 batches on group 3
    drive(4'b1000, 8191, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0);
    k = 0; n_iss = 0; n_ack = 0; last_idx = -1;
    while (!bus.port_rdy_o[3] && k < 1100) begin
      bus.wr_ack_i = (k > 0 && n_ack < 1024) ? 4'b1000 : 4'h0;
      if (bus.wr_ack_i[3]) n_ack++;
      #1;
      if (bus.issue_vld_o[3]) n_iss++;
      if (bus.last_o[3]) last_idx = int'(bus.issue_idx_o[3*BATCH_W +: BATCH_W]);
      tick();
      k++;
    end
    drive(4'h0, 0, 4'h0, 4'h0);
    check("max vl issues", n_iss, 1024);
    check("max vl last idx", last_idx, 1023);
    check("max vl rdy back", bus.port_rdy_o, 4'hf);

`ifdef PORT_TRACK_TIMEOUT_EN
    // watchdog: group 1, vl=8, never acknowledged
    drive(4'b0010, 8, 4'h0, 4'h0); tick();
    drive(4'h0, 0, 4'h0, 4'h0);
    k = 1;
    while (!bus.err_o[1] && k < 1200) begin
      tick();
      k++;
    end
    check("wdog cycle", k, 1026);
    check("wdog err", bus.err_o, 4'b0010);
    check("wdog rdy", bus.port_rdy_o, 4'hf);
    tick(); tick();
    check("wdog err sticky", bus.err_o, 4'b0010);
    rstn = 1'b0; tick();
    rstn = 1'b1;
    check("wdog err cleared", bus.err_o, 4'h0);
    tick();
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
